spi_arbiter: RTL and testbench

- Shares the single spi_interface transaction engine (work/op/len/busy handshake) between two requesters: requester 0 is spi_fsm (W5500 traffic); requester 1 is a debug/check master.
- Round-robin arbitration and per-requester parameter latching.
- A sel output steers the external FIFO muxes to the owning requester.
- A busy-start watchdog guarantees every grant terminates with a done pulse.

---
 rtl/spi_arbiter_if.sv | 52 +++++
 rtl/spi_arbiter.sv | 145 ++++++++++++++
 tb/tb_spi_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: signal bundle between the two SPI requesters, the
// spi_arbiter and the shared spi_interface transaction engine.
//
// Signals:
//   req0/op0/len0      requester 0 request level, operation, byte count
//   gnt0/done0/err0    requester 0 grant, completion and abort pulses
//   req1/op1/len1      requester 1 request level, operation, byte count
//   gnt1/done1/err1    requester 1 grant, completion and abort pulses
//   work/op/len        start pulse and latched parameters to spi_interface
//   busy               spi_interface busy
//   sel                current or last owner, steers the FIFO muxes
//   active             high from grant through done
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters + spi_interface)
interface spi_arbiter_if #(
    parameter int LEN_W = 16
);
    logic             req0;
    logic             op0;
    logic [LEN_W-1:0] len0;
    logic             gnt0;
    logic             done0;
    logic             err0;

    logic             req1;
    logic             op1;
    logic [LEN_W-1:0] len1;
    logic             gnt1;
    logic             done1;
    logic             err1;

    logic             work;
    logic             op;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             sel;
    logic             active;

    modport slave (
        input  req0, op0, len0, req1, op1, len1, busy,
        output gnt0, done0, err0, gnt1, done1, err1,
        output work, op, len, sel, active
    );

    modport master (
        output req0, op0, len0, req1, op1, len1, busy,
        input  gnt0, done0, err0, gnt1, done1, err1,
        input  work, op, len, sel, active
    );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_interface transaction engine between two
// requesters (0 = spi_fsm W5500 traffic, 1 = debug/check master).
// Round-robin arbitration, per-grant latching of op/len, FIFO mux select,
// and a busy-start watchdog so every grant ends with a done pulse.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high; aborts silently (no done)
//   bus  - spi_arbiter_if.slave: requester handshakes, work/op/len/busy
//          engine handshake, sel and active status
//
// All outputs are registered: gnt appears the cycle after the request is
// seen in IDLE, work one cycle after gnt, done in the DONE-state cycle.
module spi_arbiter #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    spi_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;     // favoured requester on contention
    logic             sel_q, sel_d;
    logic             op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             work_q, work_d;
    logic             active_q, active_d;
    logic             win_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            sel_q    <= 1'b0;
            op_q     <= 1'b0;
            len_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            work_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            len_q    <= len_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            work_q   <= work_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        op_d     = op_q;
        len_d    = len_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = '0;
        work_d   = 1'b0;
        active_d = active_q;
        win_idx  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Contention goes to the pointer; otherwise the sole requester wins.
                    win_idx        = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
                    sel_d          = win_idx;
                    op_d           = win_idx ? bus.op1  : bus.op0;
                    len_d          = win_idx ? bus.len1 : bus.len0;
                    gnt_d[win_idx] = 1'b1;
                    active_d       = 1'b1;
                    state_d        = START;
                end
            end
            START: begin
                if (len_q == '0) begin
                    // Empty transfer: complete without touching the engine.
                    done_d[sel_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    work_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.busy) begin
                    state_d = RUN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    done_d[sel_q] = 1'b1;
                    err_d[sel_q]  = 1'b1;
                    state_d       = DONE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!bus.busy) begin
                    done_d[sel_q] = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                // sel is left alone so the FIFO muxes stay put between owners.
                active_d = 1'b0;
                ptr_d    = ~sel_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0   = gnt_q[0];
    assign bus.gnt1   = gnt_q[1];
    assign bus.done0  = done_q[0];
    assign bus.done1  = done_q[1];
    assign bus.err0   = err_q[0];
    assign bus.err1   = err_q[1];
    assign bus.work   = work_q;
    assign bus.op     = op_q;
    assign bus.len    = len_q;
    assign bus.sel    = sel_q;
    assign bus.active = active_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized scenarios for spi_arbiter. Each scenario picks
// which requesters ask, their op/len, and how the engine's busy behaves; a
// transaction-level model turns that into an expected per-cycle timeline
// (grant, work, done, err, active, sel, latched op/len) that is compared
// with the DUT every cycle.
module tb_spi_arbiter;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int MAXC    = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_arbiter_if #(.LEN_W(LEN_W)) bus ();

    spi_arbiter #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected timeline and stimulus for one scenario, indexed by cycle.
    bit             e_gnt  [2][MAXC];
    bit             e_done [2][MAXC];
    bit             e_err  [2][MAXC];
    bit             e_work [MAXC];
    bit             e_act  [MAXC];
    bit             e_sel  [MAXC];
    bit             e_chk  [MAXC];
    bit             e_op   [MAXC];
    logic [LEN_W-1:0] e_len [MAXC];
    bit             b_in   [MAXC];
    bit             r_in   [2][MAXC];
    bit             op_in  [2][MAXC];
    logic [LEN_W-1:0] len_in [2][MAXC];

    // Model state carried between scenarios.
    bit m_ptr = 1'b0;
    bit m_sel = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " gnt0"},   32'(bus.gnt0),   32'd0);
        check({tag, " gnt1"},   32'(bus.gnt1),   32'd0);
        check({tag, " done0"},  32'(bus.done0),  32'd0);
        check({tag, " done1"},  32'(bus.done1),  32'd0);
        check({tag, " err0"},   32'(bus.err0),   32'd0);
        check({tag, " err1"},   32'(bus.err1),   32'd0);
        check({tag, " work"},   32'(bus.work),   32'd0);
        check({tag, " op"},     32'(bus.op),     32'd0);
        check({tag, " len"},    32'(bus.len),    32'd0);
        check({tag, " sel"},    32'(bus.sel),    32'd0);
        check({tag, " active"}, 32'(bus.active), 32'd0);
    endtask

    // mode: 0 random, 1 single req0 len5, 2 both requesting,
    //       3 watchdog on req1, 4 zero length on req0, 5 req1 only
    task automatic run_scenario(input int mode);
        int               mask, t, g, w, dc, last;
        bit               win;
        bit               pend [2];
        bit               top  [2];
        logic [LEN_W-1:0] tlen [2];
        int               dly  [2];
        int               hold [2];
        bit               never[2];
        int               g_of [2];

        for (int c = 0; c < MAXC; c++) begin
            e_work[c] = 0; e_act[c] = 0; e_chk[c] = 0; e_sel[c] = m_sel;
            e_op[c] = 0; e_len[c] = '0; b_in[c] = 0;
            for (int i = 0; i < 2; i++) begin
                e_gnt[i][c] = 0; e_done[i][c] = 0; e_err[i][c] = 0; r_in[i][c] = 0;
                op_in[i][c]  = 1'($urandom);
                len_in[i][c] = LEN_W'($urandom);
            end
        end

        mask = $urandom_range(1, 3);
        for (int i = 0; i < 2; i++) begin
            top[i] = 1'($urandom);
            case ($urandom_range(0, 7))
                0:       tlen[i] = '0;
                1:       tlen[i] = '1;
                default: tlen[i] = LEN_W'($urandom_range(1, 1000));
            endcase
            never[i] = ($urandom_range(0, 4) == 0);
            dly[i]   = $urandom_range(0, 6);
            hold[i]  = $urandom_range(1, 12);
            g_of[i]  = 0;
        end
        case (mode)
            1: begin mask = 1; top[0] = 0; tlen[0] = 5; never[0] = 0; dly[0] = 2; hold[0] = 10; end
            2: mask = 3;
            3: begin mask = 2; tlen[1] = 3; never[1] = 1; end
            4: begin mask = 1; tlen[0] = '0; end
            5: mask = 2;
            default: ;
        endcase

        // Transaction-level model: arbitration order and completion times.
        pend[0] = mask[0];
        pend[1] = mask[1];
        t = 0;
        last = 0;
        while (pend[0] || pend[1]) begin
            win = (pend[0] && pend[1]) ? m_ptr : pend[1];
            g = t + 1;
            g_of[win] = g;
            e_gnt[win][g] = 1;
            if (tlen[win] == '0) begin
                dc = g + 1;
            end else begin
                w = g + 1;
                e_work[w] = 1;
                if (never[win]) begin
                    dc = w + TIMEOUT;
                    e_err[win][dc] = 1;
                end else begin
                    for (int k = 0; k < hold[win]; k++) b_in[w + dly[win] + k] = 1;
                    dc = w + dly[win] + hold[win] + 1;
                end
            end
            e_done[win][dc] = 1;
            for (int c = g; c <= dc; c++) begin
                e_act[c] = 1; e_chk[c] = 1; e_op[c] = top[win]; e_len[c] = tlen[win];
            end
            for (int c = g; c < MAXC; c++) e_sel[c] = win;
            m_sel = win;
            m_ptr = ~win;
            pend[win] = 0;
            t = dc + 1;
            last = dc;
        end

        // Requests held until their grant; op/len change freely afterwards.
        for (int i = 0; i < 2; i++) begin
            if (mask[i]) begin
                for (int c = 0; c <= g_of[i]; c++) begin
                    r_in[i][c] = 1; op_in[i][c] = top[i]; len_in[i][c] = tlen[i];
                end
            end
        end

        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            bus.req0 = r_in[0][c]; bus.op0 = op_in[0][c]; bus.len0 = len_in[0][c];
            bus.req1 = r_in[1][c]; bus.op1 = op_in[1][c]; bus.len1 = len_in[1][c];
            bus.busy = b_in[c];
            check($sformatf("m%0d c%0d gnt0", mode, c),   32'(bus.gnt0),   32'(e_gnt[0][c]));
            check($sformatf("m%0d c%0d gnt1", mode, c),   32'(bus.gnt1),   32'(e_gnt[1][c]));
            check($sformatf("m%0d c%0d done0", mode, c),  32'(bus.done0),  32'(e_done[0][c]));
            check($sformatf("m%0d c%0d done1", mode, c),  32'(bus.done1),  32'(e_done[1][c]));
            check($sformatf("m%0d c%0d err0", mode, c),   32'(bus.err0),   32'(e_err[0][c]));
            check($sformatf("m%0d c%0d err1", mode, c),   32'(bus.err1),   32'(e_err[1][c]));
            check($sformatf("m%0d c%0d work", mode, c),   32'(bus.work),   32'(e_work[c]));
            check($sformatf("m%0d c%0d active", mode, c), 32'(bus.active), 32'(e_act[c]));
            check($sformatf("m%0d c%0d sel", mode, c),    32'(bus.sel),    32'(e_sel[c]));
            if (e_chk[c]) begin
                check($sformatf("m%0d c%0d op", mode, c),  32'(bus.op),  32'(e_op[c]));
                check($sformatf("m%0d c%0d len", mode, c), 32'(bus.len), 32'(e_len[c]));
            end
        end
    endtask

    // Reset asserted while the engine is busy: outputs clear at once and the
    // interrupted transaction never reports done.
    task automatic reset_mid_run();
        @(posedge clk); #1;
        bus.req0 = 1; bus.op0 = 1; bus.len0 = 16'd9; bus.req1 = 0; bus.busy = 0;
        @(posedge clk); #1;
        check("rr gnt0", 32'(bus.gnt0), 32'd1);
        bus.req0 = 0;
        @(posedge clk); #1;
        check("rr work", 32'(bus.work), 32'd1);
        bus.busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rr active %0d", i), 32'(bus.active), 32'd1);
            check($sformatf("rr len %0d", i), 32'(bus.len), 32'd9);
        end
        #2;
        rst = 1;
        #1;
        check_zero("rr async");
        @(negedge clk);
        bus.busy = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        m_ptr = 0;
        m_sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_zero($sformatf("rr post %0d", i));
        end
    endtask

    initial begin
        rst = 1;
        bus.req0 = 0; bus.op0 = 0; bus.len0 = '0;
        bus.req1 = 0; bus.op1 = 0; bus.len1 = '0;
        bus.busy = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 0;

        run_scenario(2);
        run_scenario(2);
        run_scenario(1);
        run_scenario(3);
        run_scenario(4);
        for (int i = 0; i < 40; i++) run_scenario(0);
        reset_mid_run();
        run_scenario(5);
        for (int i = 0; i < 10; i++) run_scenario(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
